// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write path: FSM states, default 50 MHz
// timing and the HD44780 command codes used by the init sequencer.
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP_H,
    ST_E_H,
    ST_HOLD_H,
    ST_GAP,
    ST_SETUP_L,
    ST_E_L,
    ST_HOLD_L,
    ST_WAIT,
    ST_DONE
  } lcd_state_e;

  localparam int unsigned DEF_T_SU   = 2;
  localparam int unsigned DEF_T_E    = 12;
  localparam int unsigned DEF_T_HOLD = 1;
  localparam int unsigned DEF_T_GAP  = 50;
  localparam int unsigned DEF_T_CMD  = 2000;
  localparam int unsigned DEF_T_LONG = 82000;

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;

  function automatic int unsigned max_timing(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d,
                                             input int unsigned e, input int unsigned f);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

endpackage

// File: rtl/lcd_write_engine_if.sv
// Write handshake between the init/refresh sequencer and the LCD write engine.
interface lcd_write_engine_if;
  logic       wr_enable;
  logic [7:0] wr_data;
  logic       wr_rs;
  logic       nibble_only;
  logic       long_wait;
  logic       busy;
  logic       wr_finish;

  modport master (
    output wr_enable, wr_data, wr_rs, nibble_only, long_wait,
    input  busy, wr_finish
  );

  modport slave (
    input  wr_enable, wr_data, wr_rs, nibble_only, long_wait,
    output busy, wr_finish
  );
endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd_delay_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = load_val;
    else if (cnt_q != '0) cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/lcd_write_engine.sv
// Serialises one byte onto the 4-bit HD44780 bus (high nibble first) with
// setup/enable/hold/gap timing and a post-byte execution wait.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int unsigned T_SU   = DEF_T_SU,
  parameter int unsigned T_E    = DEF_T_E,
  parameter int unsigned T_HOLD = DEF_T_HOLD,
  parameter int unsigned T_GAP  = DEF_T_GAP,
  parameter int unsigned T_CMD  = DEF_T_CMD,
  parameter int unsigned T_LONG = DEF_T_LONG
) (
  input  logic              clk,
  input  logic              rst,
  lcd_write_engine_if.slave wr,
  output logic              lcd_e,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic [3:0]        lcd_d
);
  localparam int unsigned T_MAX = max_timing(T_SU, T_E, T_HOLD, T_GAP, T_CMD, T_LONG);
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

  if (T_SU < 1 || T_E < 1 || T_HOLD < 1 || T_GAP < 1 || T_CMD < 1 || T_LONG < 1) begin : g_bad_timing
    $error("lcd_write_engine: every timing parameter must be at least 1");
  end

  lcd_state_e       state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             nib_q, nib_d;
  logic             lw_q, lw_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_done;

  lcd_delay_counter #(.WIDTH(CNT_W)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rs_q    <= 1'b0;
      nib_q   <= 1'b0;
      lw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
      lw_q    <= lw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rs_d    = rs_q;
    nib_d   = nib_q;
    lw_d    = lw_q;
    unique case (state_q)
      ST_IDLE: if (wr.wr_enable) begin
        data_d  = wr.wr_data;
        rs_d    = wr.wr_rs;
        nib_d   = wr.nibble_only;
        lw_d    = wr.long_wait;
        state_d = ST_SETUP_H;
      end
      ST_SETUP_H: if (cnt_done) state_d = ST_E_H;
      ST_E_H:     if (cnt_done) state_d = ST_HOLD_H;
      ST_HOLD_H:  if (cnt_done) state_d = nib_q ? ST_WAIT : ST_GAP;
      ST_GAP:     if (cnt_done) state_d = ST_SETUP_L;
      ST_SETUP_L: if (cnt_done) state_d = ST_E_L;
      ST_E_L:     if (cnt_done) state_d = ST_HOLD_L;
      ST_HOLD_L:  if (cnt_done) state_d = ST_WAIT;
      ST_WAIT:    if (cnt_done) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The counter is reloaded on every state change with the new state's length minus one,
  // so a state lasts exactly its parameter in cycles.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    case (state_d)
      ST_SETUP_H, ST_SETUP_L: cnt_load_val = CNT_W'(T_SU - 1);
      ST_E_H, ST_E_L:         cnt_load_val = CNT_W'(T_E - 1);
      ST_HOLD_H, ST_HOLD_L:   cnt_load_val = CNT_W'(T_HOLD - 1);
      ST_GAP:                 cnt_load_val = CNT_W'(T_GAP - 1);
      ST_WAIT:                cnt_load_val = lw_q ? CNT_W'(T_LONG - 1) : CNT_W'(T_CMD - 1);
      default:                cnt_load_val = '0;
    endcase
  end

  always_comb begin
    lcd_e        = 1'b0;
    lcd_rs       = rs_q;
    lcd_d        = data_q[7:4];
    wr.busy      = 1'b1;
    wr.wr_finish = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lcd_rs  = 1'b0;
        lcd_d   = '0;
        wr.busy = 1'b0;
      end
      ST_E_H:     lcd_e = 1'b1;
      ST_SETUP_L: lcd_d = data_q[3:0];
      ST_E_L: begin
        lcd_e = 1'b1;
        lcd_d = data_q[3:0];
      end
      ST_HOLD_L:  lcd_d = data_q[3:0];
      ST_WAIT:    lcd_d = nib_q ? data_q[7:4] : data_q[3:0];
      ST_DONE: begin
        lcd_d        = nib_q ? data_q[7:4] : data_q[3:0];
        wr.wr_finish = 1'b1;
      end
      default: ;
    endcase
  end

  assign lcd_rw = 1'b0;
endmodule

// File: tb/tb_lcd_write_engine.sv
// Randomised scoreboard bench for lcd_write_engine with shortened timing.
module tb_lcd_write_engine;
  import lcd_pkg::*;

  localparam int unsigned SU   = 2;
  localparam int unsigned EW   = 4;
  localparam int unsigned HO   = 1;
  localparam int unsigned GP   = 6;
  localparam int unsigned CMD  = 20;
  localparam int unsigned LONG = 60;

  typedef struct {
    logic [3:0] d;
    logic       rs;
    int         gap;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  lcd_write_engine_if wr();

  lcd_write_engine #(
    .T_SU(SU), .T_E(EW), .T_HOLD(HO), .T_GAP(GP), .T_CMD(CMD), .T_LONG(LONG)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_rw (lcd_rw),
    .lcd_d  (lcd_d)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     vectors = 0;
  int     miscompares = 0;
  pulse_t pulse_q[$];
  int     fin_q[$];
  int     start_c = 0;
  int     busy_until = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a strobe is taken only once the previous transfer's DONE cycle has passed.
  task automatic issue(input logic [7:0] d, input logic rs, input logic nib, input logic lw);
    int     t;
    int     lat;
    pulse_t p;
    wr.wr_enable   = 1'b1;
    wr.wr_data     = d;
    wr.wr_rs       = rs;
    wr.nibble_only = nib;
    wr.long_wait   = lw;
    t = cyc;
    if (t > busy_until) begin
      lat = 1 + (nib ? 1 : 2) * int'(SU + EW + HO) + (nib ? 0 : int'(GP)) + int'(lw ? LONG : CMD);
      p.d = d[7:4]; p.rs = rs; p.gap = 0;
      pulse_q.push_back(p);
      if (!nib) begin
        p.d = d[3:0]; p.gap = int'(HO + GP + SU);
        pulse_q.push_back(p);
      end
      fin_q.push_back(t + lat);
      start_c    = t;
      busy_until = t + lat;
    end
    @(posedge clk); #1;
    wr.wr_enable   = 1'b0;
    wr.wr_data     = 8'($urandom);
    wr.wr_rs       = 1'($urandom);
    wr.nibble_only = 1'($urandom);
    wr.long_wait   = 1'($urandom);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_finish();
    bit seen = 1'b0;
    for (int i = 0; i < int'(LONG) * 2 + 200; i++) begin
      if (wr.wr_finish) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(seen, "finish_timeout", longint'(seen), 1);
  endtask

  // Bus monitor and scoreboard
  logic       e_prev = 1'b0;
  logic [4:0] prev_bus = '0;
  int         hi_cnt = 0;
  int         last_chg = 0;
  int         last_fall = -100;
  bit         exp_busy;
  bit         ok;
  pulse_t     cur;
  int         exp_fin;

  always @(negedge clk) begin
    if (rst) begin
      e_prev    = 1'b0;
      hi_cnt    = 0;
      prev_bus  = {lcd_rs, lcd_d};
      last_chg  = cyc;
      last_fall = -100;
    end else begin
      exp_busy = (cyc > start_c) && (cyc <= busy_until);
      chk(wr.busy === exp_busy, "busy", longint'(wr.busy), longint'(exp_busy));
      chk(lcd_rw === 1'b0, "lcd_rw", longint'(lcd_rw), 0);
      if (!exp_busy)
        chk({lcd_e, lcd_rs, lcd_d} === 6'b0, "idle_bus", longint'({lcd_e, lcd_rs, lcd_d}), 0);

      if ({lcd_rs, lcd_d} !== prev_bus) begin
        chk(cyc - last_fall >= int'(HO), "hold", cyc - last_fall, HO);
        chk(!(lcd_e && e_prev), "bus_change_during_e", longint'({lcd_rs, lcd_d}), longint'(prev_bus));
        last_chg = cyc;
      end

      if (lcd_e && !e_prev) begin
        hi_cnt = 1;
        ok = (pulse_q.size() > 0);
        chk(ok, "extra_e_pulse", longint'(lcd_d), -1);
        if (ok) begin
          cur = pulse_q.pop_front();
          chk(lcd_d === cur.d, "e_nibble", longint'(lcd_d), longint'(cur.d));
          chk(lcd_rs === cur.rs, "e_rs", longint'(lcd_rs), longint'(cur.rs));
          chk(cyc - last_chg >= int'(SU), "setup", cyc - last_chg, SU);
          if (cur.gap != 0)
            chk(cyc - last_fall == cur.gap, "nibble_gap", cyc - last_fall, cur.gap);
        end
      end else if (lcd_e) begin
        hi_cnt++;
      end
      if (!lcd_e && e_prev) begin
        chk(hi_cnt == int'(EW), "e_width", hi_cnt, EW);
        last_fall = cyc;
      end

      if (wr.wr_finish) begin
        ok = (fin_q.size() > 0);
        chk(ok, "unexpected_finish", cyc, -1);
        if (ok) begin
          exp_fin = fin_q.pop_front();
          chk(cyc == exp_fin, "finish_cycle", cyc, exp_fin);
        end
      end
      if (fin_q.size() > 0 && cyc > fin_q[0]) begin
        chk(cyc <= fin_q[0], "finish_missing", cyc, fin_q[0]);
        void'(fin_q.pop_front());
      end

      e_prev   = lcd_e;
      prev_bus = {lcd_rs, lcd_d};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] cmds[4];
  int         t0;
  int         lat;

  initial begin
    wr.wr_enable   = 1'b0;
    wr.wr_data     = '0;
    wr.wr_rs       = 1'b0;
    wr.nibble_only = 1'b0;
    wr.long_wait   = 1'b0;
    cmds[0] = CMD_FUNCTION_SET;
    cmds[1] = CMD_ENTRY_MODE;
    cmds[2] = CMD_DISPLAY_ON;
    cmds[3] = CMD_CLEAR;

    repeat (3) @(posedge clk);
    #1;
    chk({lcd_e, lcd_rs, lcd_rw, lcd_d, wr.busy, wr.wr_finish} === 9'b0, "reset_outputs",
        longint'({lcd_e, lcd_rs, lcd_rw, lcd_d, wr.busy, wr.wr_finish}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Data write with stray strobes mid-transfer and in DONE, then an immediate restart
    issue(8'h41, 1'b1, 1'b0, 1'b0);
    t0 = start_c; lat = busy_until - t0;
    wait_cyc(t0 + 5);   issue(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    wait_cyc(t0 + 20);  issue(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    wait_cyc(t0 + lat); issue(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    issue(8'h5A, 1'b0, 1'b0, 1'b0);
    wait_cyc(busy_until + 3);

    issue(8'h30, 1'b0, 1'b1, 1'b0);
    wait_cyc(busy_until + 2);
    issue(8'h01, 1'b0, 1'b0, 1'b1);
    wait_cyc(busy_until + 2);

    // Reset while the low-nibble enable pulse is high
    issue(8'hA5, 1'b1, 1'b0, 1'b0);
    t0 = start_c;
    wait_cyc(t0 + 1 + int'(SU + EW + HO + GP + SU) + 1);
    #1;
    chk(lcd_e === 1'b1, "pre_reset_e", longint'(lcd_e), 1);
    rst = 1'b1;
    #1;
    chk(lcd_e === 1'b0, "reset_e_async", longint'(lcd_e), 0);
    chk({lcd_rs, lcd_rw, lcd_d, wr.busy, wr.wr_finish} === 8'b0, "reset_mid_outputs",
        longint'({lcd_rs, lcd_rw, lcd_d, wr.busy, wr.wr_finish}), 0);
    pulse_q.delete();
    fin_q.delete();
    start_c = 0;
    busy_until = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(8'hC3, 1'b1, 1'b0, 1'b0);
    wait_cyc(busy_until + 2);

    // Sequencer-driven init bytes, each issued in the first IDLE cycle after wr_finish
    foreach (cmds[i]) begin
      issue(cmds[i], 1'b0, 1'b0, cmds[i] == CMD_CLEAR);
      wait_finish();
      @(posedge clk); #1;
    end
    wait_cyc(busy_until + 2);

    for (int n = 0; n < 25; n++) begin
      issue(8'($urandom), 1'($urandom), 1'($urandom_range(3) == 0), 1'($urandom_range(4) == 0));
      for (int k = 0; k < 3; k++) begin
        wait_cyc(cyc + int'($urandom_range(40)));
        if ($urandom_range(1) == 1)
          issue(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      wait_cyc(busy_until + 1 + int'($urandom_range(3)));
    end
    wait_cyc(busy_until + 3);

    chk(fin_q.size() == 0, "finish_queue_empty", fin_q.size(), 0);
    chk(pulse_q.size() == 0, "pulse_queue_empty", pulse_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lcd_write_engine.md
Name: lcd_write_engine

Overview:
Responder side of the LCD write handshake: accepts a one-cycle wr_enable strobe plus a byte and RS flag from the init/refresh sequencer. Drives the 4-bit HD44780-style character LCD bus, upper nibble first and then lower nibble, meeting setup, enable-width, hold and execution timing. Returns a one-cycle wr_finish pulse when the LCD is ready for the next write. Sits between the sequencer/mux and the LCD pins.

Parameters:
T_SU, 2, cycles RS/data stable before E rises (40 ns at 50 MHz)
T_E, 12, cycles E held high (240 ns)
T_HOLD, 1, cycles data held after E falls
T_GAP, 50, cycles between nibbles (1 us)
T_CMD, 2000, post-byte execution wait (40 us)
T_LONG, 82000, post-byte wait when long_wait=1 (clear/home, 1.64 ms)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wr_enable  in  1  single-cycle write request, sampled only in IDLE
wr_data  in  8  byte to write
wr_rs  in  1  0=command, 1=data
nibble_only  in  1  send wr_data[7:4] only (power-on init writes)
long_wait  in  1  use T_LONG instead of T_CMD
busy  out  1  high in every state except IDLE
wr_finish  out  1  one-cycle completion pulse
lcd_e  out  1  LCD enable
lcd_rs  out  1  LCD register select
lcd_rw  out  1  tied 0 (write-only)
lcd_d  out  4  LCD data nibble

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high.
- Reset: state IDLE; counter 0; lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, busy=0, wr_finish=0; latched byte, rs and flags = 0.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- States: IDLE, SETUP_H, E_H, HOLD_H, GAP, SETUP_L, E_L, HOLD_L, WAIT, DONE.
- Each timed state loads its down-counter on entry and exits when the counter expires. The state lasts exactly its parameter in cycles.
- IDLE: on wr_enable=1, latch wr_data, wr_rs, nibble_only and long_wait, then go to SETUP_H. lcd_d=0, lcd_rs=0 while in IDLE.
- SETUP_H, E_H, HOLD_H: lcd_d=byte[7:4], lcd_rs=latched rs. lcd_e=1 only in E_H.
- After HOLD_H: if nibble_only go to WAIT, otherwise go to GAP. GAP keeps lcd_e=0 and lcd_d unchanged.
- SETUP_L, E_L, HOLD_L: lcd_d=byte[3:0]. lcd_e=1 only in E_L.
- WAIT: lcd_e=0 for T_LONG cycles if long_wait was latched, else T_CMD.
- DONE: wr_finish=1 for exactly one cycle, then IDLE.
- Latency, taking the wr_enable cycle as cycle 0 and using defaults:
  - Full byte: wr_finish high in cycle 1+2*(T_SU+T_E+T_HOLD)+T_GAP+T_CMD = 2081.
  - Nibble-only: wr_finish in cycle 1+T_SU+T_E+T_HOLD+T_CMD = 2016.
  - With long_wait, substitute T_LONG for T_CMD.
- wr_enable while busy (including DONE) is ignored. No queueing, no error flag.
- Input changes after the capture cycle have no effect on the transfer in progress.
- Counter width is $clog2 of the largest parameter, plus 1. Every parameter must be ≥1; an elaboration-time check enforces this.
- Reset mid-transfer: immediate return to IDLE; lcd_e drops asynchronously; no wr_finish is issued.
- Exactly one E pulse per nibble; lcd_e is never high in two non-contiguous runs within one nibble.

Decomposition:
- Shared package lcd_pkg holds:
  - the state encoding;
  - default timing constants (T_SU, T_E, T_HOLD, T_GAP, T_CMD, T_LONG at 50 MHz);
  - common HD44780 command codes (0x28 function set, 0x06 entry mode, 0x0C display on, 0x01 clear).
- One natural sub-module, lcd_delay_counter: loadable down-counter with a done flag, reused for every timed state.

Test Plan:
- Reset, then wr_enable with wr_data=0x41, wr_rs=1 -> lcd_d=0x4 during the first E pulse (12 cycles), 0x1 during the second, lcd_rs=1 throughout, wr_finish in cycle 2081, busy low in cycle 2082.
- nibble_only=1, wr_data=0x30, wr_rs=0 -> single E pulse with lcd_d=0x3, lcd_rs=0, wr_finish in cycle 2016.
- long_wait=1, wr_data=0x01 -> two E pulses (0x0 then 0x1), wr_finish in cycle 81+82000 = 82081.
- Extra wr_enable pulses in cycles 5, 500 and in the DONE cycle -> ignored: exactly one wr_finish, bus values unchanged. wr_enable in the first IDLE cycle after DONE starts a new transfer.
- Assert rst during E_L -> lcd_e=0 in the same cycle, all outputs at reset values, no wr_finish. The next write completes normally.
- Back-to-back sequence 0x28, 0x06, 0x0C, 0x01 driven by a sequencer model -> four wr_finish pulses; the E high-to-next-E-rise spacing within each byte is ≥ T_HOLD+T_GAP+T_SU = 53 cycles.
